// File: rtl/poly_arith_pkg.sv
// poly_arith_pkg: shared constants and Barrett reduction helper for mod-3329 arithmetic
package poly_arith_pkg;
  localparam int Q = 3329;
  localparam int COEFF_W = 12;
  localparam int PROD_W = 24;
  localparam int REDUCE_LAT_DEFAULT = 2;
  localparam int BARRETT_K = 24;
  localparam int BARRETT_M = (1 << BARRETT_K) / Q;
  localparam int MUL_W = 40;
  localparam int REM_W = 14;

  // Quotient estimate undershoots by at most 2, so two conditional subtractions finish the job.
  function automatic logic [COEFF_W-1:0] barrett_reduce(input logic [PROD_W-1:0] x);
    logic [PROD_W-1:0] q;
    logic [REM_W-1:0] r;
    q = PROD_W'((MUL_W'(x) * MUL_W'(BARRETT_M)) >> BARRETT_K);
    r = REM_W'(x - q * PROD_W'(Q));
    r = (r >= REM_W'(Q)) ? r - REM_W'(Q) : r;
    r = (r >= REM_W'(Q)) ? r - REM_W'(Q) : r;
    return COEFF_W'(r);
  endfunction
endpackage

// File: rtl/modular_reduce.sv
// modular_reduce: fixed-latency, non-stallable reduction of a 24-bit product modulo 3329
module modular_reduce
  import poly_arith_pkg::*;
#(
  parameter int LAT = REDUCE_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [PROD_W-1:0]  value_i,
  output logic               valid_o,
  output logic [COEFF_W-1:0] value_o
);
  logic [LAT-1:0] vld;
  logic [COEFF_W-1:0] dat [LAT];

  // Valid shift chain; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst)
    if (rst) vld <= '0;
    else vld <= LAT'({vld, valid_i});

  // Reduced value enters at stage 0 and is delayed alongside its valid bit.
  always_ff @(posedge clk) begin
    dat[0] <= barrett_reduce(value_i);
    for (int i = 1; i < LAT; i++) dat[i] <= dat[i-1];
  end

  assign valid_o = vld[LAT-1];
  assign value_o = dat[LAT-1];
endmodule

// File: rtl/mod_mul_stream.sv
// mod_mul_stream: streaming (a*b) mod 3329 with credit-based result FIFO; MOD_MUL_RANGE_CHECK_EN adds sticky err_o
module mod_mul_stream
  import poly_arith_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int REDUCE_LAT = REDUCE_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] coeff_a_i,
  input  logic [COEFF_W-1:0] coeff_b_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] result_o
`ifdef MOD_MUL_RANGE_CHECK_EN
  ,
  output logic               err_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(REDUCE_LAT + 2);

  logic accept, pop, prod_valid, red_valid;
  logic [PROD_W-1:0] prod;
  logic [COEFF_W-1:0] red_value;
  logic [COEFF_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;

  assign accept = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  // Reserving a slot for every pair still in the pipeline means the non-stallable reducer can never overflow the FIFO.
  assign in_ready = rst_n && (int'(count) + int'(inflight) < FIFO_DEPTH);
  assign out_valid = count != '0;
  assign result_o = out_valid ? mem[rd_ptr] : '0;

  // Product valid flag follows acceptance by one cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prod_valid <= 1'b0;
    else prod_valid <= accept;

  // Product data only needs capturing on acceptance.
  always_ff @(posedge clk)
    if (accept) prod <= PROD_W'(coeff_a_i) * PROD_W'(coeff_b_i);

  modular_reduce #(.LAT(REDUCE_LAT)) u_reduce (
    .clk     (clk),
    .rst     (!rst_n),
    .valid_i (prod_valid),
    .value_i (prod),
    .valid_o (red_valid),
    .value_o (red_value)
  );

  // FIFO pointers, occupancy and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      inflight <= '0;
    end else begin
      if (red_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(red_valid) - CW'(pop);
      inflight <= inflight + IW'(accept) - IW'(red_valid);
    end

  // FIFO storage; every reducer output is written unconditionally.
  always_ff @(posedge clk)
    if (red_valid) mem[wr_ptr] <= red_value;

`ifdef MOD_MUL_RANGE_CHECK_EN
  // Sticky flag for any accepted operand outside [0, Q-1].
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_o <= 1'b0;
    else if (accept && (coeff_a_i >= COEFF_W'(Q) || coeff_b_i >= COEFF_W'(Q))) err_o <= 1'b1;
`endif
endmodule

// File: tb/tb_mod_mul_stream.sv
// tb_mod_mul_stream: directed and scoreboarded checks of mod_mul_stream
module tb_mod_mul_stream;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [11:0] coeff_a = '0, coeff_b = '0, result;
  logic w_in_valid = 1'b0, w_in_ready, w_out_valid;
  logic [11:0] w_a = '0, w_b = '0, w_result;
`ifdef MOD_MUL_RANGE_CHECK_EN
  logic err, w_err;
`endif
  int checks = 0, errors = 0;
  int op_a[$], op_b[$];

  mod_mul_stream u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coeff_a_i (coeff_a),
    .coeff_b_i (coeff_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_o  (result)
`ifdef MOD_MUL_RANGE_CHECK_EN
    ,
    .err_o     (err)
`endif
  );

  mod_mul_stream #(.FIFO_DEPTH(8)) u_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .coeff_a_i (w_a),
    .coeff_b_i (w_b),
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .result_o  (w_result)
`ifdef MOD_MUL_RANGE_CHECK_EN
    ,
    .err_o     (w_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic int mm(input int a, input int b);
    return (a * b) % 3329;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
  endtask

  task automatic lat_vec(input int a, input int b, input int expv);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    coeff_a = 12'(a);
    coeff_b = 12'(b);
    check("lat_ready", in_ready, 1);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 20);
    check("lat_cycles", n, 4);
    check("lat_result", result, expv);
    @(negedge clk);
    check("lat_popped", out_valid, 0);
  endtask

  task automatic stream(input int hold, input bit rnd, input int budget);
    int idx, got, cyc;
    int exp_q[$];
    idx = 0;
    got = 0;
    cyc = 0;
    while (got < op_a.size() && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hold > 0 && cyc == hold + 1) begin
        check("stall_accepted", idx, 4);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
      end
      out_ready = (cyc <= hold) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else check("stream_result", result, exp_q.pop_front());
        got++;
      end
      in_valid = idx < op_a.size() && (!rnd || $urandom_range(0, 3) != 0);
      if (in_valid) begin
        coeff_a = 12'(op_a[idx]);
        coeff_b = 12'(op_b[idx]);
        if (in_ready) begin
          exp_q.push_back(mm(op_a[idx], op_b[idx]));
          idx++;
        end
      end
    end
    check("stream_count", got, op_a.size());
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_no_dup", out_valid, 0);
    check("stream_left", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    apply_reset();
    lat_vec(3328, 3328, 1);
    lat_vec(0, 1234, 0);
    lat_vec(1665, 2, 1);
    lat_vec(1, 1, 1);

    op_a = '{10, 20, 3328, 0, 1665, 1234};
    op_b = '{30, 3328, 3328, 77, 2, 2};
    stream(10, 1'b0, 200);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      coeff_a = 12'(100 + i);
      coeff_b = 12'd7;
      check("pre_rst_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("stale_results", n, 0);

    op_a.delete();
    op_b.delete();
    for (int i = 0; i < 10000; i++) begin
      op_a.push_back($urandom_range(0, 3328));
      op_b.push_back($urandom_range(0, 3328));
    end
    stream(0, 1'b1, 60000);

    begin
      int idx, got, stalls, gaps;
      int q[$];
      idx = 0;
      got = 0;
      stalls = 0;
      gaps = 0;
      for (int c = 0; c < 60 && got < 20; c++) begin
        @(negedge clk);
        if (w_out_valid) begin
          if (q.size() == 0) check("wide_extra", 1, 0);
          else check("wide_result", w_result, q.pop_front());
          got++;
        end else if (got > 0) gaps++;
        w_in_valid = idx < 20;
        w_a = 12'((idx * 397 + 11) % 3329);
        w_b = 12'((idx * 1103 + 5) % 3329);
        if (w_in_valid) begin
          if (w_in_ready) begin
            q.push_back(mm(int'(w_a), int'(w_b)));
            idx++;
          end else stalls++;
        end
      end
      w_in_valid = 1'b0;
      check("wide_count", got, 20);
      check("wide_stalls", stalls, 0);
      check("wide_gaps", gaps, 0);
    end

`ifdef MOD_MUL_RANGE_CHECK_EN
    check("err_init", err, 0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    coeff_a = 12'd3329;
    coeff_b = 12'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("err_set", err, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("err_res_valid", out_valid, 1);
    check("err_result", result, 0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("err_hold", err, 1);
    check("err_drained", out_valid, 0);
    apply_reset();
    check("err_clear", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
